aes_inv_round_ctrl: RTL and testbench

AES_INV_ROUND_CTRL -- requirements
Module: aes_inv_round_ctrl

---
 rtl/aes_pkg.sv | 27 ++
 rtl/aes_inv_round_ctrl_fsm.sv | 93 +++++++++
 rtl/aes_inv_round_ctrl.sv | 108 ++++++++++
 tb/tb_aes_inv_round_ctrl.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg
// Shared constants and types for the AES inverse-cipher round controller.
//
// Contents:
//   NR_128, NR_256   round counts for the two supported key sizes
//   BLOCK_LENGTH     AES state width in bits
//   ctrl_state_e     controller FSM states (IDLE, RUN, DONE)
//   rounds_for_key   maps a key length in bits to its round count
package aes_pkg;

    localparam int NR_128       = 10;
    localparam int NR_256       = 14;
    localparam int BLOCK_LENGTH = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_state_e;

    // The caller rejects illegal key lengths separately, so anything that
    // is not 256 is treated as the 128-bit case here.
    function automatic logic [3:0] rounds_for_key(input int keyLength);
        return (keyLength == 256) ? 4'(NR_256) : 4'(NR_128);
    endfunction

endpackage

// File: rtl/aes_inv_round_ctrl_fsm.sv
// aes_inv_round_ctrl_fsm
// Sequencing core of the inverse-round controller: the IDLE/RUN/DONE state
// machine and the round counter. It carries no block data; the parent owns
// the state register and uses load_o/step_o to decide how it updates.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   in_valid_i   ciphertext offered by the producer
//   out_ready_i  plaintext accepted by the consumer
//   abort_i      synchronous flush back to IDLE
//   state_o      current FSM state
//   rnd_o        current round counter value
//   load_o       this edge accepts a new block (initial AddRoundKey)
//   step_o       this edge commits one inverse round result
module aes_inv_round_ctrl_fsm
    import aes_pkg::*;
#(
    parameter logic [3:0] NR = 4'd10
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        in_valid_i,
    input  logic        out_ready_i,
    input  logic        abort_i,
    output ctrl_state_e state_o,
    output logic [3:0]  rnd_o,
    output logic        load_o,
    output logic        step_o
);

    ctrl_state_e state_q;
    ctrl_state_e state_d;
    logic [3:0]  rnd_q;
    logic [3:0]  rnd_d;

    // FSM state and round counter registers. Reset lands in IDLE with the
    // counter cleared so no stale round index survives a reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rnd_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
        end
    end

    // Next-state logic. Abort outranks every other request, and a block is
    // only taken from IDLE, so a new block can never overlap the previous
    // one. The counter runs NR-1 down to 0 and the zero round exits to DONE
    // rather than decrementing, so it cannot wrap.
    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        load_o  = 1'b0;
        step_o  = 1'b0;

        if (abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        load_o  = 1'b1;
                        rnd_d   = NR - 4'd1;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    step_o = 1'b1;
                    if (rnd_q != 4'd0) begin
                        rnd_d = rnd_q - 4'd1;
                    end else begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign state_o = state_q;
    assign rnd_o   = rnd_q;

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// aes_inv_round_ctrl
// Round controller for an iterative AES inverse cipher. It holds the block
// state, walks the round-key index from Nr down to 0 and hands the state to
// an external inverse-round datapath, writing that datapath's result back
// every cycle. No cryptographic logic lives here.
//
// Parameters:
//   KEY_LENGTH    128 (Nr=10) or 256 (Nr=14); anything else stops elaboration
//   BLOCK_LENGTH  state width
//
// Ports:
//   CLK         clock, rising edge
//   RST_n       asynchronous active-low reset
//   in_valid    ciphertext offered        in_ready   block can be taken
//   IN          ciphertext block
//   abort       synchronous flush to IDLE (state contents kept)
//   rk_idx      round-key index to the key store
//   rk          round key for rk_idx, combinational
//   rnd_state   state sent to the datapath
//   rnd_last    final round: datapath skips InvMixColumns
//   rnd_result  datapath output, combinational
//   out_valid   plaintext available       out_ready  consumer takes it
//   OUT         plaintext (the state register)
//   busy        high in RUN or DONE
module aes_inv_round_ctrl #(
    parameter int KEY_LENGTH   = 128,
    parameter int BLOCK_LENGTH = aes_pkg::BLOCK_LENGTH
) (
    input  logic                    CLK,
    input  logic                    RST_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BLOCK_LENGTH-1:0] IN,
    input  logic                    abort,
    output logic [3:0]              rk_idx,
    input  logic [BLOCK_LENGTH-1:0] rk,
    output logic [BLOCK_LENGTH-1:0] rnd_state,
    output logic                    rnd_last,
    input  logic [BLOCK_LENGTH-1:0] rnd_result,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BLOCK_LENGTH-1:0] OUT,
    output logic                    busy
);

    import aes_pkg::*;

    if ((KEY_LENGTH != 128) && (KEY_LENGTH != 256)) begin : gen_bad_key_length
        $error("aes_inv_round_ctrl: KEY_LENGTH must be 128 or 256");
    end

    localparam logic [3:0] NR = rounds_for_key(KEY_LENGTH);

    ctrl_state_e             fsmState;
    logic [3:0]              rnd;
    logic                    loadBlock;
    logic                    stepRound;
    logic [BLOCK_LENGTH-1:0] blockState_q;
    logic [BLOCK_LENGTH-1:0] blockState_d;

    aes_inv_round_ctrl_fsm #(
        .NR          (NR)
    ) u_fsm (
        .clk_i       (CLK),
        .rst_ni      (RST_n),
        .in_valid_i  (in_valid),
        .out_ready_i (out_ready),
        .abort_i     (abort),
        .state_o     (fsmState),
        .rnd_o       (rnd),
        .load_o      (loadBlock),
        .step_o      (stepRound)
    );

    // Block state register. Cleared on reset so OUT reads zero until the
    // first block has been processed.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            blockState_q <= '0;
        end else begin
            blockState_q <= blockState_d;
        end
    end

    // State update. While IDLE the key store is pointed at round key Nr, so
    // accepting a block performs the initial AddRoundKey here. In RUN the
    // datapath result is committed each cycle. Abort suppresses both
    // through the FSM strobes, leaving the contents untouched.
    always_comb begin
        blockState_d = blockState_q;
        if (loadBlock) begin
            blockState_d = IN ^ rk;
        end else if (stepRound) begin
            blockState_d = rnd_result;
        end
    end

    // All outputs decode registered state only; handshake inputs never
    // reach an output combinationally.
    assign in_ready  = (fsmState == IDLE);
    assign busy      = (fsmState == RUN) || (fsmState == DONE);
    assign out_valid = (fsmState == DONE);
    assign rk_idx    = (fsmState == RUN) ? rnd : NR;
    assign rnd_last  = (fsmState == RUN) && (rnd == 4'd0);
    assign rnd_state = blockState_q;
    assign OUT       = blockState_q;

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// tb_aes_inv_round_ctrl
// Self-checking bench for aes_inv_round_ctrl. Instantiates an AES-128 and an
// AES-256 controller, each closed around a behavioural inverse-round datapath
// and key store built from a software AES model (S-box derived from GF(2^8)
// inverses, FIPS-197 key expansion). Expected plaintexts come from the
// FIPS-197 known answers or from the model's full inverse cipher.
module tb_aes_inv_round_ctrl;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic              RST_n;
    logic [1:0]        inValid;
    logic [1:0]        abortIn;
    logic [1:0]        outReady;
    logic [1:0]        inReady;
    logic [1:0]        rndLast;
    logic [1:0]        outValid;
    logic [1:0]        busy;
    logic [1:0][3:0]   rkIdx;
    logic [1:0][127:0] inData;
    logic [1:0][127:0] rkIn;
    logic [1:0][127:0] rndState;
    logic [1:0][127:0] rndResult;
    logic [1:0][127:0] outData;

    logic [7:0]   sboxT    [256];
    logic [7:0]   invSboxT [256];
    logic [127:0] rkTab    [2][16];

    int nVectors     = 0;
    int nMiscompares = 0;

    localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;

    // Behavioural key store and inverse-round datapath for both instances.
    assign rkIn[0]      = rkTab[0][rkIdx[0]];
    assign rkIn[1]      = rkTab[1][rkIdx[1]];
    assign rndResult[0] = invRound(rndState[0], rkIn[0], rndLast[0]);
    assign rndResult[1] = invRound(rndState[1], rkIn[1], rndLast[1]);

    aes_inv_round_ctrl #(.KEY_LENGTH(128), .BLOCK_LENGTH(128)) dut128 (
        .CLK(CLK), .RST_n(RST_n), .in_valid(inValid[0]), .in_ready(inReady[0]),
        .IN(inData[0]), .abort(abortIn[0]), .rk_idx(rkIdx[0]), .rk(rkIn[0]),
        .rnd_state(rndState[0]), .rnd_last(rndLast[0]), .rnd_result(rndResult[0]),
        .out_valid(outValid[0]), .out_ready(outReady[0]), .OUT(outData[0]), .busy(busy[0])
    );

    aes_inv_round_ctrl #(.KEY_LENGTH(256), .BLOCK_LENGTH(128)) dut256 (
        .CLK(CLK), .RST_n(RST_n), .in_valid(inValid[1]), .in_ready(inReady[1]),
        .IN(inData[1]), .abort(abortIn[1]), .rk_idx(rkIdx[1]), .rk(rkIn[1]),
        .rnd_state(rndState[1]), .rnd_last(rndLast[1]), .rnd_result(rndResult[1]),
        .out_valid(outValid[1]), .out_ready(outReady[1]), .OUT(outData[1]), .busy(busy[1])
    );

    function automatic int nrOf(input int k);
        return (k == 0) ? 10 : 14;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {sboxT[w[31:24]], sboxT[w[23:16]], sboxT[w[15:8]], sboxT[w[7:0]]};
    endfunction

    // One inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
    // InvMixColumns unless this is the final round. Byte i of the block is
    // column i/4, row i%4.
    function automatic logic [127:0] invRound(input logic [127:0] s, input logic [127:0] key,
                                              input logic last);
        logic [7:0]   a [16];
        logic [7:0]   coef [4];
        logic [7:0]   m;
        logic [127:0] res;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                a[4*c+r] = invSboxT[s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8]]
                           ^ key[127 - 8*(4*c + r) -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                if (last) begin
                    m = a[4*c+r];
                end else begin
                    m = 8'h00;
                    for (int j = 0; j < 4; j++) m = m ^ gmul(coef[(j - r + 4) % 4], a[4*c+j]);
                end
                res[127 - 8*(4*c + r) -: 8] = m;
            end
        return res;
    endfunction

    function automatic logic [127:0] modelDecrypt(input int k, input logic [127:0] ct);
        logic [127:0] st;
        int nr;
        nr = nrOf(k);
        st = ct ^ rkTab[k][nr];
        for (int r = nr - 1; r >= 0; r--) st = invRound(st, rkTab[k][r], r == 0);
        return st;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic buildSbox();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sboxT[x]    = s;
            invSboxT[s] = 8'(x);
        end
    endtask

    task automatic expandKey(input int k, input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk;
        int nr;
        nk = (k == 0) ? 4 : 8;
        nr = nrOf(k);
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subWord({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subWord(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) rkTab[k][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Offers one block to instance k from IDLE, follows it through every
    // round, optionally stalls the consumer, then completes the handshake.
    task automatic runBlock(input int k, input logic [127:0] ct, input logic [127:0] expPt,
                            input int holdCycles, input string tag);
        int nr;
        int cyc;
        nr = nrOf(k);
        nVectors++;
        if (inReady[k] !== 1'b1 || busy[k] !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL %s.idle: in_ready=%b busy=%b expected 1/0", tag, inReady[k], busy[k]);
        end
        nVectors++;
        if (rkIdx[k] !== 4'(nr)) begin
            nMiscompares++;
            $display("[TB] FAIL %s.rk_idx_idle: got %0d expected %0d", tag, rkIdx[k], nr);
        end
        inValid[k] = 1'b1;
        inData[k]  = ct;
        tick();
        inValid[k] = 1'b0;
        cyc = 0;
        while (outValid[k] !== 1'b1 && cyc < 40) begin
            nVectors++;
            if (rkIdx[k] !== 4'(nr - 1 - cyc)) begin
                nMiscompares++;
                $display("[TB] FAIL %s.rk_idx[%0d]: got %0d expected %0d", tag, cyc, rkIdx[k], nr - 1 - cyc);
            end
            nVectors++;
            if (rndLast[k] !== (cyc == nr - 1) || inReady[k] !== 1'b0) begin
                nMiscompares++;
                $display("[TB] FAIL %s.run[%0d]: rnd_last=%b in_ready=%b expected %b/0",
                         tag, cyc, rndLast[k], inReady[k], (cyc == nr - 1));
            end
            tick();
            cyc++;
        end
        nVectors++;
        if (cyc != nr) begin
            nMiscompares++;
            $display("[TB] FAIL %s.latency: got %0d edges expected %0d", tag, cyc, nr);
        end
        nVectors++;
        if (outData[k] !== expPt || rndState[k] !== expPt) begin
            nMiscompares++;
            $display("[TB] FAIL %s.out: OUT=%h rnd_state=%h expected %h", tag, outData[k], rndState[k], expPt);
        end
        nVectors++;
        if (inReady[k] !== 1'b0 || rndLast[k] !== 1'b0 || busy[k] !== 1'b1) begin
            nMiscompares++;
            $display("[TB] FAIL %s.done_flags: in_ready=%b rnd_last=%b busy=%b expected 0/0/1",
                     tag, inReady[k], rndLast[k], busy[k]);
        end
        for (int h = 0; h < holdCycles; h++) begin
            tick();
            nVectors++;
            if (outValid[k] !== 1'b1 || outData[k] !== expPt || inReady[k] !== 1'b0) begin
                nMiscompares++;
                $display("[TB] FAIL %s.hold[%0d]: out_valid=%b in_ready=%b OUT=%h expected 1/0/%h",
                         tag, h, outValid[k], inReady[k], outData[k], expPt);
            end
        end
        outReady[k] = 1'b1;
        tick();
        outReady[k] = 1'b0;
        nVectors++;
        if (outValid[k] !== 1'b0 || inReady[k] !== 1'b1 || busy[k] !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL %s.release: out_valid=%b in_ready=%b busy=%b expected 0/1/0",
                     tag, outValid[k], inReady[k], busy[k]);
        end
    endtask

    task automatic test_reset();
        tick();
        for (int k = 0; k < 2; k++) begin
            nVectors++;
            if (outValid[k] !== 1'b0 || busy[k] !== 1'b0 || rndLast[k] !== 1'b0 || inReady[k] !== 1'b1) begin
                nMiscompares++;
                $display("[TB] FAIL reset.flags[%0d]: out_valid=%b busy=%b rnd_last=%b in_ready=%b expected 0/0/0/1",
                         k, outValid[k], busy[k], rndLast[k], inReady[k]);
            end
            nVectors++;
            if (outData[k] !== 128'h0 || rkIdx[k] !== 4'(nrOf(k))) begin
                nMiscompares++;
                $display("[TB] FAIL reset.values[%0d]: OUT=%h rk_idx=%0d expected 0/%0d",
                         k, outData[k], rkIdx[k], nrOf(k));
            end
        end
        RST_n = 1'b1;
        tick();
    endtask

    task automatic test_fips_128();
        runBlock(0, C1_CT, FIPS_PT, 0, "fips128");
    endtask

    task automatic test_fips_256();
        runBlock(1, C3_CT, FIPS_PT, 0, "fips256");
    endtask

    task automatic test_backpressure();
        logic [127:0] ct;
        ct = rand128();
        runBlock(0, ct, modelDecrypt(0, ct), 20, "backpressure");
    endtask

    task automatic test_abort();
        logic [127:0] ct;
        logic [127:0] st;
        logic [127:0] pt;
        int cyc;
        ct = rand128();
        st = ct ^ rkTab[0][10];
        for (int r = 9; r > 5; r--) st = invRound(st, rkTab[0][r], 1'b0);
        inValid[0] = 1'b1;
        inData[0]  = ct;
        tick();
        inValid[0] = 1'b0;
        repeat (4) tick();
        nVectors++;
        if (rkIdx[0] !== 4'd5 || rndState[0] !== st) begin
            nMiscompares++;
            $display("[TB] FAIL abort.at_rnd5: rk_idx=%0d state=%h expected 5/%h", rkIdx[0], rndState[0], st);
        end
        abortIn[0] = 1'b1;
        inValid[0] = 1'b1;
        inData[0]  = ~ct;
        tick();
        abortIn[0] = 1'b0;
        inValid[0] = 1'b0;
        nVectors++;
        if (busy[0] !== 1'b0 || inReady[0] !== 1'b1 || outValid[0] !== 1'b0 || rndState[0] !== st) begin
            nMiscompares++;
            $display("[TB] FAIL abort.run: busy=%b in_ready=%b out_valid=%b state=%h expected 0/1/0/%h",
                     busy[0], inReady[0], outValid[0], rndState[0], st);
        end
        cyc = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (outValid[0] !== 1'b0 || busy[0] !== 1'b0) cyc++;
        end
        nVectors++;
        if (cyc != 0) begin
            nMiscompares++;
            $display("[TB] FAIL abort.quiet: %0d active cycles expected 0", cyc);
        end
        abortIn[0] = 1'b1;
        inValid[0] = 1'b1;
        tick();
        abortIn[0] = 1'b0;
        inValid[0] = 1'b0;
        nVectors++;
        if (busy[0] !== 1'b0 || rndState[0] !== st) begin
            nMiscompares++;
            $display("[TB] FAIL abort.idle: busy=%b state=%h expected 0/%h", busy[0], rndState[0], st);
        end
        ct = rand128();
        pt = modelDecrypt(0, ct);
        inValid[0] = 1'b1;
        inData[0]  = ct;
        tick();
        inValid[0] = 1'b0;
        cyc = 0;
        while (outValid[0] !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        nVectors++;
        if (cyc != 10) begin
            nMiscompares++;
            $display("[TB] FAIL abort.reach_done: got %0d edges expected 10", cyc);
        end
        abortIn[0] = 1'b1;
        tick();
        abortIn[0] = 1'b0;
        nVectors++;
        if (outValid[0] !== 1'b0 || inReady[0] !== 1'b1 || outData[0] !== pt) begin
            nMiscompares++;
            $display("[TB] FAIL abort.done: out_valid=%b in_ready=%b OUT=%h expected 0/1/%h",
                     outValid[0], inReady[0], outData[0], pt);
        end
    endtask

    task automatic test_async_reset();
        inValid[0] = 1'b1;
        inData[0]  = C1_CT;
        tick();
        inValid[0] = 1'b0;
        repeat (3) tick();
        #2;
        RST_n = 1'b0;
        #1;
        nVectors++;
        if (busy[0] !== 1'b0 || outValid[0] !== 1'b0 || inReady[0] !== 1'b1 || rndLast[0] !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL async_reset.flags: busy=%b out_valid=%b in_ready=%b rnd_last=%b expected 0/0/1/0",
                     busy[0], outValid[0], inReady[0], rndLast[0]);
        end
        nVectors++;
        if (outData[0] !== 128'h0 || rkIdx[0] !== 4'd10) begin
            nMiscompares++;
            $display("[TB] FAIL async_reset.values: OUT=%h rk_idx=%0d expected 0/10", outData[0], rkIdx[0]);
        end
        #3;
        RST_n = 1'b1;
        tick();
        runBlock(0, C1_CT, FIPS_PT, 0, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [127:0] ct1;
        logic [127:0] ct2;
        int cyc;
        int lastCount;
        ct1 = rand128();
        ct2 = rand128();
        inValid[0]  = 1'b1;
        inData[0]   = ct1;
        outReady[0] = 1'b1;
        for (int b = 0; b < 2; b++) begin
            tick();
            nVectors++;
            if (busy[0] !== 1'b1) begin
                nMiscompares++;
                $display("[TB] FAIL b2b.accept[%0d]: busy=%b expected 1", b, busy[0]);
            end
            if (b == 1) inValid[0] = 1'b0;
            cyc = 0;
            lastCount = 0;
            while (outValid[0] !== 1'b1 && cyc < 40) begin
                if (rndLast[0] === 1'b1) lastCount++;
                tick();
                cyc++;
            end
            nVectors++;
            if (cyc != 10 || lastCount != 1) begin
                nMiscompares++;
                $display("[TB] FAIL b2b.block[%0d]: latency=%0d rnd_last_cycles=%0d expected 10/1", b, cyc, lastCount);
            end
            nVectors++;
            if (outData[0] !== modelDecrypt(0, (b == 0) ? ct1 : ct2)) begin
                nMiscompares++;
                $display("[TB] FAIL b2b.out[%0d]: got %h expected %h", b, outData[0],
                         modelDecrypt(0, (b == 0) ? ct1 : ct2));
            end
            tick();
            nVectors++;
            if (busy[0] !== 1'b0 || inReady[0] !== 1'b1) begin
                nMiscompares++;
                $display("[TB] FAIL b2b.gap[%0d]: busy=%b in_ready=%b expected 0/1", b, busy[0], inReady[0]);
            end
            inData[0] = ct2;
        end
        outReady[0] = 1'b0;
    endtask

    task automatic test_random();
        logic [255:0] key;
        logic [127:0] ct;
        int k;
        for (int n = 0; n < 6; n++) begin
            k   = n % 2;
            key = {rand128(), rand128()};
            expandKey(k, key);
            ct  = rand128();
            runBlock(k, ct, modelDecrypt(k, ct), int'($urandom_range(0, 3)), "random");
        end
    endtask

    initial begin
        RST_n    = 1'b0;
        inValid  = '0;
        abortIn  = '0;
        outReady = '0;
        inData   = '0;
        buildSbox();
        expandKey(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
        expandKey(1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        $display("[TB] starting aes_inv_round_ctrl bench");
        test_reset();
        test_fips_128();
        test_fips_256();
        test_backpressure();
        test_abort();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
